// File: rtl/ddr2_avl_pkg.sv
// Shared types and constants for the DDR2 Avalon traffic master: state
// encoding, bus widths and the fixed bytes of the test pattern.
package ddr2_avl_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 64;

    localparam logic [7:0] PAT_HI = 8'hA5;
    localparam logic [7:0] PAT_LO = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        WRITE,
        READ,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/ddr2_avl_patgen.sv
// Address-to-pattern function: each word carries its own address and its
// complement so stuck, swapped or aliased address bits all show up as data errors.
module ddr2_avl_patgen
    import ddr2_avl_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign data = {PAT_HI, addr, PAT_LO, ~addr};

endmodule

// File: rtl/ddr2_avl_traffic_master.sv
// Write-then-read-back sweep over DDR2 through the controller's Avalon port,
// with bounded read pipelining and in-order data checking.
module ddr2_avl_traffic_master
    import ddr2_avl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_LAST = 24'h000FFF,
    parameter int                MAX_OUTST = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              local_init_done,
    input  logic              local_cal_success,
    input  logic              local_cal_fail,
    input  logic              start,
    input  logic              avl_ready,
    output logic              avl_write_req,
    output logic              avl_read_req,
    output logic              avl_burstbegin,
    output logic [ADDR_W-1:0] avl_addr,
    output logic              avl_size,
    output logic [DATA_W-1:0] avl_wdata,
    input  logic [DATA_W-1:0] avl_rdata,
    input  logic              avl_rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cal_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [3:0] OUTST_LIM = 4'(MAX_OUTST);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, exp_addr;
    logic [3:0]        outst;
    logic              cmd_pend, first_seen, abort_seen;
    logic [DATA_W-1:0] wr_pat, exp_pat;
    logic              in_test, abort, wr_acc, rd_acc, rd_beat, mismatch;

    ddr2_avl_patgen u_wr_pat  (.addr(addr),     .data(wr_pat));
    ddr2_avl_patgen u_exp_pat (.addr(exp_addr), .data(exp_pat));

    assign busy           = (state != IDLE);
    assign avl_write_req  = (state == WRITE);
    assign avl_read_req   = (state == READ) && (outst < OUTST_LIM);
    assign avl_burstbegin = (avl_write_req || avl_read_req) && !cmd_pend;
    assign avl_addr       = (avl_write_req || avl_read_req) ? addr : '0;
    assign avl_wdata      = avl_write_req ? wr_pat : '0;
    assign avl_size       = 1'b1;

    assign in_test  = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign abort    = in_test && (abort_seen || !local_init_done);
    assign wr_acc   = avl_write_req && avl_ready;
    assign rd_acc   = avl_read_req && avl_ready;
    // Beats outside READ/DRAIN belong to an aborted sweep and are dropped.
    assign rd_beat  = avl_rdata_valid && ((state == READ) || (state == DRAIN));
    assign mismatch = rd_beat && (avl_rdata != exp_pat);

    // NOTE: state is sequential, so it takes non-blocking assignments only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through the case can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = WAIT_CAL;
            WAIT_CAL: begin
                if (local_cal_fail)                            state_nxt = FINISH;
                else if (local_init_done && local_cal_success) state_nxt = WRITE;
            end
            WRITE: begin
                if (wr_acc) begin
                    if (abort)                  state_nxt = FINISH;
                    else if (addr == ADDR_LAST) state_nxt = READ;
                end
            end
            READ: begin
                // An abort lets a presented read finish its handshake first.
                if (rd_acc) begin
                    if (abort)                  state_nxt = FINISH;
                    else if (addr == ADDR_LAST) state_nxt = DRAIN;
                end else if (abort && !avl_read_req) begin
                    state_nxt = FINISH;
                end
            end
            DRAIN:    if (abort || (outst == '0)) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr           <= '0;
            exp_addr       <= '0;
            outst          <= '0;
            cmd_pend       <= 1'b0;
            first_seen     <= 1'b0;
            abort_seen     <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            cal_err        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done     <= (state == FINISH);
            cmd_pend <= (avl_write_req || avl_read_req) && !avl_ready;

            if ((state == IDLE) && start) begin
                addr           <= '0;
                exp_addr       <= '0;
                outst          <= '0;
                first_seen     <= 1'b0;
                abort_seen     <= 1'b0;
                pass           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end

            if ((state == WAIT_CAL) && local_cal_fail) cal_err <= 1'b1;
            if (in_test && !local_init_done) begin
                cal_err    <= 1'b1;
                abort_seen <= 1'b1;
            end

            if (wr_acc) addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
            if (rd_acc) addr <= addr + 1'b1;

            case ({rd_acc, rd_beat})
                2'b10:   outst <= outst + 4'd1;
                2'b01:   if (outst != '0) outst <= outst - 4'd1;
                default: ;
            endcase

            if (rd_beat) exp_addr <= exp_addr + 1'b1;
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
                if (!first_seen) begin
                    first_seen     <= 1'b1;
                    first_err_addr <= exp_addr;
                end
            end

            if (state == FINISH) pass <= (err_count == '0) && !cal_err;
        end
    end

endmodule
